// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch-queue entry layout and the RISC-V opcode values used around fetch.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [63:0] npc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundles the imem request/response channel, branch control and decode-latch outputs.
// master = fetch stage, slave = memory/decode environment.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        LD_DE;
  logic        v_de_br_stall;
  logic        br_redirect;
  logic [63:0] br_target;
  logic [63:0] DE_NPC;
  logic [31:0] DE_IR;
  logic        DE_V;

  modport master (
    output imem_req_valid, imem_req_addr, DE_NPC, DE_IR, DE_V,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           LD_DE, v_de_br_stall, br_redirect, br_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, DE_NPC, DE_IR, DE_V,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           LD_DE, v_de_br_stall, br_redirect, br_target
  );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO for fetched instructions; head is readable combinationally.
// Zero-latency pop of head, one-cycle push-to-visible; push and pop may coincide, flush wins.
module fetch_queue #(
  parameter  int DEPTH = 2,
  parameter  int W     = 96,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A push into a full queue that is not being drained would silently lose an entry.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop && !flush));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues in-order imem requests, queues responses, feeds the decode latch.
// Redirect-to-DE_IR is 3 cycles with a 1-cycle memory; request stalls when outstanding+queued reaches FQ_DEPTH.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          reset,
  fetch_stage_if.master fif
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int DW = 8;

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] drop_cnt;

  logic          de_v;
  logic [31:0]   de_ir;
  logic [63:0]   de_npc;

  logic [CW-1:0] fq_count;
  logic          fq_empty;
  logic          fq_full;
  logic          fq_push;
  logic          fq_pop;
  fetch_entry_t  fq_head;
  fetch_entry_t  resp_entry;

  logic          req_fire;
  logic          resp_hit_drop;
  logic          resp_live;
  logic          resp_ok;
  logic          ld_go;
  logic          bypass;

  // Cap counts owned in-flight requests plus queued entries so every owned response has a slot.
  assign fif.imem_req_valid = reset && !fif.br_redirect &&
                              ((int'(outstanding) + int'(fq_count)) < FQ_DEPTH);
  assign fif.imem_req_addr  = fetch_pc;
  assign req_fire           = fif.imem_req_valid && fif.imem_req_ready;

  assign resp_hit_drop = fif.imem_resp_valid && (drop_cnt != '0);
  assign resp_live     = fif.imem_resp_valid && (drop_cnt == '0);
  assign resp_ok       = resp_live && !fif.br_redirect;

  assign resp_entry.npc = resp_pc + 64'd4;
  assign resp_entry.ir  = fif.imem_resp_data;

  assign ld_go   = fif.LD_DE && !fif.br_redirect && !fif.v_de_br_stall;
  assign fq_pop  = ld_go && !fq_empty;
  assign bypass  = ld_go && fq_empty && resp_ok;
  assign fq_push = resp_ok && !bypass;

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .W     (FETCH_ENTRY_W)
  ) u_fetch_queue (
    .clk      (CLK),
    .rst_n    (reset),
    .push     (fq_push),
    .push_dat (resp_entry),
    .pop      (fq_pop),
    .flush    (fif.br_redirect),
    .head_dat (fq_head),
    .count    (fq_count),
    .empty    (fq_empty),
    .full     (fq_full)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (fif.br_redirect) begin
      fetch_pc    <= align_pc(fif.br_target);
      resp_pc     <= align_pc(fif.br_target);
      outstanding <= '0;
      // Everything still in flight, owned or already doomed, must be discarded on return.
      drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(fif.imem_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 64'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_live);
      if (resp_hit_drop) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
      if (resp_ok) begin
        resp_pc <= resp_pc + 64'd4;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      de_v   <= 1'b0;
      de_ir  <= NOP_INSN;
      de_npc <= RESET_PC;
    end else if (fif.br_redirect) begin
      de_v <= 1'b0;
    end else if (fif.LD_DE) begin
      if (fif.v_de_br_stall) begin
        de_v <= 1'b0;
      end else if (!fq_empty) begin
        de_v   <= 1'b1;
        de_ir  <= fq_head.ir;
        de_npc <= fq_head.npc;
      end else if (resp_ok) begin
        de_v   <= 1'b1;
        de_ir  <= resp_entry.ir;
        de_npc <= resp_entry.npc;
      end else begin
        de_v <= 1'b0;
      end
    end
  end

  assign fif.DE_V   = de_v;
  assign fif.DE_IR  = de_ir;
  assign fif.DE_NPC = de_npc;

  a_fq_no_overflow: assert property (@(posedge CLK) disable iff (!reset)
    !(fq_push && fq_full && !fq_pop));

  a_no_orphan_resp: assert property (@(posedge CLK) disable iff (!reset)
    resp_live |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_0000_0000;

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  fetch_stage_if fif();

  fetch_stage #(.RESET_PC(RST_PC), .FQ_DEPTH(2)) dut (
    .CLK   (CLK),
    .reset (reset),
    .fif   (fif)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  int cyc = 0;
  int last_due = 0;
  int lat_lo = 1, lat_hi = 1;
  bit rdy_rand = 0;
  int delivered = 0;

  logic        c_ld = 1'b1, c_stall = 1'b0, c_redir = 1'b0;
  logic [63:0] c_target = '0;

  logic [63:0] exp_pc = RST_PC, exp_fetch = RST_PC;
  bit          have_prev = 0;
  logic        p_ld, p_stall, p_redir, p_dev;
  logic [31:0] p_ir;
  logic [63:0] p_npc, p_target;

  logic        s_req_v, s_dev;
  logic [63:0] s_req_addr, s_npc;
  logic [31:0] s_ir;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    if (a == 64'h0) return 32'h0000_0013;
    if (a == 64'h4) return 32'h0010_0093;
    h = a[31:0] * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Program-order model: each load of the latch must be the next sequential PC since the last redirect.
  task automatic check_latch();
    if (!have_prev) return;
    if (p_redir) begin
      chk("redir_de_v", fif.DE_V, 0);
      exp_pc = {p_target[63:2], 2'b00};
    end else if (!p_ld) begin
      chk("hold_de_v", fif.DE_V, p_dev);
      chk("hold_de_ir", fif.DE_IR, p_ir);
      chk("hold_de_npc", fif.DE_NPC, p_npc);
    end else if (p_stall) begin
      chk("stall_de_v", fif.DE_V, 0);
    end else if (fif.DE_V) begin
      chk("de_npc", fif.DE_NPC, exp_pc + 64'd4);
      chk("de_ir", fif.DE_IR, mem_word(exp_pc));
      exp_pc = exp_pc + 64'd4;
      delivered++;
    end
  endtask

  // Starts and ends at a negedge; the DUT sees one rising edge in between.
  task automatic step();
    int lat, due;
    check_latch();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      fif.imem_resp_valid = 1'b1;
      fif.imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      fif.imem_resp_valid = 1'b0;
      fif.imem_resp_data  = 32'hDEAD_BEEF;
    end
    fif.imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    fif.LD_DE          = c_ld;
    fif.v_de_br_stall  = c_stall;
    fif.br_redirect    = c_redir;
    fif.br_target      = c_target;
    #1;
    s_req_v    = fif.imem_req_valid;
    s_req_addr = fif.imem_req_addr;
    s_dev      = fif.DE_V;
    s_ir       = fif.DE_IR;
    s_npc      = fif.DE_NPC;
    if (c_redir) begin
      chk("redir_req_valid", s_req_v, 0);
    end else if (s_req_v) begin
      chk("req_addr", s_req_addr, exp_fetch);
    end
    if (s_req_v && fif.imem_req_ready) begin
      lat = $urandom_range(lat_lo, lat_hi);
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      mq.push_back('{addr: s_req_addr, due: due});
      exp_fetch = exp_fetch + 64'd4;
    end
    if (c_redir) exp_fetch = {c_target[63:2], 2'b00};
    p_ld = c_ld; p_stall = c_stall; p_redir = c_redir; p_target = c_target;
    p_dev = s_dev; p_ir = s_ir; p_npc = s_npc;
    have_prev = 1;
    @(negedge CLK);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    fif.imem_resp_valid = 1'b0;
    fif.br_redirect = 1'b0;
    #1;
    chk("rst_req_valid", fif.imem_req_valid, 0);
    chk("rst_de_v", fif.DE_V, 0);
    chk("rst_de_ir", fif.DE_IR, NOP_INSN);
    chk("rst_de_npc", fif.DE_NPC, RST_PC);
    mq.delete();
    last_due = cyc;
    repeat (n) @(negedge CLK);
    chk("rst_hold_req_valid", fif.imem_req_valid, 0);
    reset = 1'b1;
    exp_pc = RST_PC;
    exp_fetch = RST_PC;
    have_prev = 0;
  endtask

  task automatic wait_dev(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = s_dev;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    logic [63:0] br_npc;
    logic [31:0] r0, r1;
    fif.imem_req_ready = 1'b0; fif.imem_resp_valid = 1'b0; fif.imem_resp_data = '0;
    fif.LD_DE = 1'b0; fif.v_de_br_stall = 1'b0; fif.br_redirect = 1'b0; fif.br_target = '0;
    @(negedge CLK);
    do_reset(2);

    // Cold start, 1-cycle memory.
    step(); chk("first_req_valid", s_req_v, 1); chk("first_req_addr", s_req_addr, RST_PC);
    step(); chk("de_v_before_resp", s_dev, 0);
    step(); chk("de_v_rise", s_dev, 1); chk("first_npc", s_npc, 64'h4); chk("first_ir", s_ir, 32'h0000_0013);
    step(); chk("second_npc", s_npc, 64'h8); chk("second_ir", s_ir, 32'h0010_0093);

    // Decode holds for 5 cycles.
    c_ld = 1'b0;
    repeat (5) step();
    chk("hold_req_stops", s_req_v, 0);
    c_ld = 1'b1;
    repeat (6) step();

    // Branch stall for 3 cycles.
    repeat (4) step();
    c_stall = 1'b1;
    step(); br_npc = s_npc; chk("pre_stall_v", s_dev, 1);
    step();
    step(); chk("stall_prefetch_full", s_req_v, 0);
    c_stall = 1'b0;
    wait_dev("post_stall_timeout", 10);
    chk("post_stall_npc", s_npc, br_npc + 64'd4);

    // Redirect with a slower memory so responses are in flight.
    lat_lo = 3; lat_hi = 3;
    repeat (6) step();
    c_redir = 1'b1; c_target = 64'h1003;
    step();
    c_redir = 1'b0;
    wait_dev("redir_timeout", 20);
    chk("redir_first_npc", s_npc, 64'h1004);
    chk("redir_first_ir", s_ir, mem_word(64'h1000));

    // Redirect coincident with a response, 1-cycle memory: 3-cycle latency.
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();
    c_redir = 1'b1; c_target = 64'h2000;
    step(); chk("coinc_no_req", s_req_v, 0);
    c_redir = 1'b0;
    step(); chk("coinc_de_v_low", s_dev, 0);
    step();
    step(); chk("coinc_latency_v", s_dev, 1); chk("coinc_latency_npc", s_npc, 64'h2004);

    // PC wrap at 2^64.
    c_redir = 1'b1; c_target = 64'hFFFF_FFFF_FFFF_FFFA;
    step();
    c_redir = 1'b0;
    wait_dev("wrap_timeout", 10);
    chk("wrap_first_npc", s_npc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(); chk("wrap_second_npc", s_npc, 64'h0);

    // Reset mid-stream with the queue full.
    c_ld = 1'b0;
    repeat (4) step();
    do_reset(1);
    c_ld = 1'b1;
    step(); chk("post_rst_req_valid", s_req_v, 1); chk("post_rst_req_addr", s_req_addr, RST_PC);

    // Randomised traffic against the program-order model.
    rdy_rand = 1; lat_lo = 1; lat_hi = 4;
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      c_ld    = ($urandom_range(0, 3) != 0);
      c_stall = ($urandom_range(0, 9) == 0);
      c_redir = ($urandom_range(0, 29) == 0);
      r0 = $urandom; r1 = $urandom;
      c_target = ($urandom_range(0, 7) == 0) ? {32'hFFFF_FFFF, 28'hFFFF_FFF, r0[3:0]} : {r1, r0};
      if (i == 1000) do_reset(1);
      step();
    end
    chk("random_liveness", delivered > 200, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
